// File: rtl/test_engine_driver.sv
`default_nettype none
// ============================================================================
// test_engine_driver : NIC-side initiator for the test engine handshake.
// Rev 1.0 - initial release
// ============================================================================
module test_engine_driver #(
  parameter int WORD_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid_din,
  input  logic [WORD_WIDTH-1:0]  in_wordA_din,
  input  logic [WORD_WIDTH-1:0]  in_wordB_din,
  output logic                   in_ready_dout,
  output logic                   start_strobe_dout,
  output logic [WORD_WIDTH-1:0]  wordA_dout,
  output logic [WORD_WIDTH-1:0]  wordB_dout,
  input  logic                   done_strobe_din,
  input  logic                   active_test_engine_din,
  input  logic [WORD_WIDTH-1:0]  wordC_din,
  input  logic [WORD_WIDTH-1:0]  wordD_din,
  output logic                   out_valid_dout,
  output logic [WORD_WIDTH-1:0]  out_wordC_dout,
  output logic [WORD_WIDTH-1:0]  out_wordD_dout,
  input  logic                   out_ready_din,
  output logic                   timeout_dout,
  output logic                   busy_dout,
  output logic [COUNT_WIDTH-1:0] packet_count_dout,
  output logic [COUNT_WIDTH-1:0] timeout_count_dout,
  output logic [COUNT_WIDTH-1:0] spurious_count_dout
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_START  = 2'd1;
  localparam logic [1:0] c_WAIT   = 2'd2;
  localparam logic [1:0] c_OUTPUT = 2'd3;

  localparam logic [WAIT_W-1:0]      c_WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] c_CNT_MAX   = {COUNT_WIDTH{1'b1}};

  logic [1:0]             state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [WORD_WIDTH-1:0]  word_a_q, word_a_d, word_b_q, word_b_d;
  logic [WORD_WIDTH-1:0]  word_c_q, word_c_d, word_d_q, word_d_d;
  logic [COUNT_WIDTH-1:0] pkt_q, pkt_d, to_q, to_d, spur_q, spur_d;

  // The engine busy flag is informational only.
  logic w_unused;
  assign w_unused = active_test_engine_din;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == c_CNT_MAX) ? v : v + COUNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= c_IDLE;
      wait_q   <= '0;
      word_a_q <= '0;
      word_b_q <= '0;
      word_c_q <= '0;
      word_d_q <= '0;
      pkt_q    <= '0;
      to_q     <= '0;
      spur_q   <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      word_a_q <= word_a_d;
      word_b_q <= word_b_d;
      word_c_q <= word_c_d;
      word_d_q <= word_d_d;
      pkt_q    <= pkt_d;
      to_q     <= to_d;
      spur_q   <= spur_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    word_a_d = word_a_q;
    word_b_d = word_b_q;
    word_c_d = word_c_q;
    word_d_d = word_d_q;
    pkt_d    = pkt_q;
    to_d     = to_q;
    spur_d   = spur_q;
    case (state_q)
      c_IDLE: begin
        if (in_valid_din) begin
          word_a_d = in_wordA_din;
          word_b_d = in_wordB_din;
          state_d  = c_START;
        end
      end
      c_START: begin
        wait_d  = '0;
        state_d = c_WAIT;
      end
      c_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        // A done on the threshold cycle still delivers the result.
        if (done_strobe_din) begin
          word_c_d = wordC_din;
          word_d_d = wordD_din;
          pkt_d    = sat_inc(pkt_q);
          state_d  = c_OUTPUT;
        end else if (wait_q == c_WAIT_LAST) begin
          to_d    = sat_inc(to_q);
          state_d = c_IDLE;
        end
      end
      c_OUTPUT: begin
        if (out_ready_din) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
    if (done_strobe_din && (state_q != c_WAIT)) spur_d = sat_inc(spur_q);
  end

  always_comb begin
    in_ready_dout     = 1'b0;
    start_strobe_dout = 1'b0;
    out_valid_dout    = 1'b0;
    timeout_dout      = 1'b0;
    busy_dout         = (state_q != c_IDLE);
    case (state_q)
      // Held low while reset is asserted so every output reads zero.
      c_IDLE:   in_ready_dout     = ~reset;
      c_START:  start_strobe_dout = 1'b1;
      c_WAIT:   timeout_dout      = ~done_strobe_din && (wait_q == c_WAIT_LAST);
      c_OUTPUT: out_valid_dout    = 1'b1;
      default:  ;
    endcase
  end

  assign wordA_dout          = word_a_q;
  assign wordB_dout          = word_b_q;
  assign out_wordC_dout      = word_c_q;
  assign out_wordD_dout      = word_d_q;
  assign packet_count_dout   = pkt_q;
  assign timeout_count_dout  = to_q;
  assign spurious_count_dout = spur_q;

endmodule
`default_nettype wire

// File: tb/tb_test_engine_driver.sv
`default_nettype none
// ============================================================================
// tb_test_engine_driver : directed + randomized bench with a cycle-level model.
// Rev 1.0 - initial release
// ============================================================================
module tb_test_engine_driver;

  localparam int W  = 64;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid_din, in_ready_dout, start_strobe_dout;
  logic [W-1:0]  in_wordA_din, in_wordB_din, wordA_dout, wordB_dout;
  logic          done_strobe_din, active_test_engine_din;
  logic [W-1:0]  wordC_din, wordD_din, out_wordC_dout, out_wordD_dout;
  logic          out_valid_dout, out_ready_din, timeout_dout, busy_dout;
  logic [CW-1:0] packet_count_dout, timeout_count_dout, spurious_count_dout;

  test_engine_driver #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid_din(in_valid_din), .in_wordA_din(in_wordA_din), .in_wordB_din(in_wordB_din),
    .in_ready_dout(in_ready_dout), .start_strobe_dout(start_strobe_dout),
    .wordA_dout(wordA_dout), .wordB_dout(wordB_dout),
    .done_strobe_din(done_strobe_din), .active_test_engine_din(active_test_engine_din),
    .wordC_din(wordC_din), .wordD_din(wordD_din),
    .out_valid_dout(out_valid_dout), .out_wordC_dout(out_wordC_dout),
    .out_wordD_dout(out_wordD_dout), .out_ready_din(out_ready_din),
    .timeout_dout(timeout_dout), .busy_dout(busy_dout),
    .packet_count_dout(packet_count_dout), .timeout_count_dout(timeout_count_dout),
    .spurious_count_dout(spurious_count_dout)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: last delivered result and event tallies.
  logic [W-1:0] exp_c, exp_d;
  int           exp_pkt, exp_to, exp_spur;

  function automatic int sat(input int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_in_ready", W'(in_ready_dout), '0);
    chk("rst_start", W'(start_strobe_dout), '0);
    chk("rst_wordA", wordA_dout, '0);
    chk("rst_wordB", wordB_dout, '0);
    chk("rst_out_valid", W'(out_valid_dout), '0);
    chk("rst_wordC", out_wordC_dout, '0);
    chk("rst_wordD", out_wordD_dout, '0);
    chk("rst_timeout", W'(timeout_dout), '0);
    chk("rst_busy", W'(busy_dout), '0);
    chk("rst_pkt_cnt", W'(packet_count_dout), '0);
    chk("rst_to_cnt", W'(timeout_count_dout), '0);
    chk("rst_spur_cnt", W'(spurious_count_dout), '0);
  endtask

  task automatic model_reset();
    exp_c = '0; exp_d = '0; exp_pkt = 0; exp_to = 0; exp_spur = 0;
  endtask

  // One IDLE cycle presenting a packet; checks the idle-side view of the model.
  task automatic idle_accept(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid_din = 1'b1; in_wordA_din = a; in_wordB_din = b;
    done_strobe_din = 1'b0; out_ready_din = 1'b0;
    wordC_din = rnd64(); wordD_din = rnd64();
    active_test_engine_din = 1'($urandom);
    #1;
    chk("idle_in_ready", W'(in_ready_dout), W'(1));
    chk("idle_busy", W'(busy_dout), '0);
    chk("idle_out_valid", W'(out_valid_dout), '0);
    chk("idle_start", W'(start_strobe_dout), '0);
    chk("idle_wordC", out_wordC_dout, exp_c);
    chk("idle_wordD", out_wordD_dout, exp_d);
    chk("pkt_cnt", W'(packet_count_dout), W'(exp_pkt));
    chk("to_cnt", W'(timeout_count_dout), W'(exp_to));
    chk("spur_cnt", W'(spurious_count_dout), W'(exp_spur));
  endtask

  task automatic start_cycle(input logic [W-1:0] a, input logic [W-1:0] b, input logic hold);
    @(negedge clk);
    in_valid_din = hold; in_wordA_din = rnd64(); in_wordB_din = rnd64();
    #1;
    chk("start_strobe", W'(start_strobe_dout), W'(1));
    chk("start_in_ready", W'(in_ready_dout), '0);
    chk("start_busy", W'(busy_dout), W'(1));
    chk("start_wordA", wordA_dout, a);
    chk("start_wordB", wordB_dout, b);
  endtask

  // Full transaction: engine answers (swapped words) lat cycles after the
  // strobe, or never within the window when lat > TO (then a late done).
  task automatic run_packet(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int lat, input int bp, input logic hold_in);
    logic hold;
    int   last;
    hold = hold_in && (lat <= TO);
    idle_accept(a, b);
    start_cycle(a, b, hold);
    last = (lat < TO) ? lat : TO;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      in_wordA_din    = rnd64(); in_wordB_din = rnd64();
      done_strobe_din = (k == lat);
      wordC_din       = (k == lat) ? b : rnd64();
      wordD_din       = (k == lat) ? a : rnd64();
      #1;
      chk("wait_start", W'(start_strobe_dout), '0);
      chk("wait_in_ready", W'(in_ready_dout), '0);
      chk("wait_out_valid", W'(out_valid_dout), '0);
      chk("wait_wordA", wordA_dout, a);
      chk("wait_timeout", W'(timeout_dout), W'((k == TO) && (lat > TO)));
    end
    if (lat <= TO) begin
      exp_pkt = sat(exp_pkt); exp_c = b; exp_d = a;
      for (int j = 0; j <= bp; j++) begin
        @(negedge clk);
        done_strobe_din = 1'b0; out_ready_din = (j == bp);
        wordC_din = rnd64(); wordD_din = rnd64();
        #1;
        chk("out_valid", W'(out_valid_dout), W'(1));
        chk("out_wordC", out_wordC_dout, exp_c);
        chk("out_wordD", out_wordD_dout, exp_d);
        chk("out_in_ready", W'(in_ready_dout), '0);
        chk("out_timeout", W'(timeout_dout), '0);
      end
    end else begin
      exp_to = sat(exp_to);
      for (int k = TO + 1; k <= lat; k++) begin
        @(negedge clk);
        in_valid_din = 1'b0; done_strobe_din = (k == lat);
        wordC_din = rnd64(); wordD_din = rnd64();
        #1;
        chk("post_to_in_ready", W'(in_ready_dout), W'(1));
        chk("post_to_out_valid", W'(out_valid_dout), '0);
        chk("post_to_timeout", W'(timeout_dout), '0);
        if (k == lat) exp_spur = sat(exp_spur);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid_din = 1'b0; in_wordA_din = '0; in_wordB_din = '0;
    done_strobe_din = 1'b0; active_test_engine_din = 1'b0;
    wordC_din = '0; wordD_din = '0; out_ready_din = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero();
    @(negedge clk);
    reset = 1'b0;

    // Single packet, swapped result after 16 cycles.
    run_packet(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 16, 0, 1'b0);
    // Backpressure for 10 cycles.
    run_packet(rnd64(), rnd64(), 7, 10, 1'b0);
    // Back-to-back with in_valid held high.
    for (int i = 0; i < 4; i++) run_packet(rnd64(), rnd64(), 1 + i, 0, 1'b1);
    // Timeout, followed by a late done.
    run_packet(rnd64(), rnd64(), TO + 8, 0, 1'b0);
    // Done exactly on the timeout threshold.
    run_packet(rnd64(), rnd64(), TO, 1, 1'b0);

    // Done strobes while idle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid_din = 1'b0; done_strobe_din = 1'b1;
      wordC_din = rnd64(); wordD_din = rnd64();
      #1;
      chk("spur_out_valid", W'(out_valid_dout), '0);
      exp_spur = sat(exp_spur);
    end

    // Reset five cycles after the strobe.
    idle_accept(64'hAAAA_0000_5555_FFFF, 64'h0123_4567_89AB_CDEF);
    start_cycle(64'hAAAA_0000_5555_FFFF, 64'h0123_4567_89AB_CDEF, 1'b0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      done_strobe_din = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run_packet(rnd64(), rnd64(), 3, 0, 1'b0);

    // Randomized traffic mix.
    for (int i = 0; i < 20; i++) begin
      int r, lat;
      r = int'($urandom_range(0, 9));
      if (r < 6)      lat = int'($urandom_range(1, TO - 1));
      else if (r < 8) lat = TO;
      else            lat = int'($urandom_range(TO + 1, TO + 8));
      run_packet(rnd64(), rnd64(), lat, int'($urandom_range(0, 3)), 1'($urandom));
    end

    @(negedge clk);
    in_valid_din = 1'b0; done_strobe_din = 1'b0;
    #1;
    chk("final_pkt_cnt", W'(packet_count_dout), W'(exp_pkt));
    chk("final_to_cnt", W'(timeout_count_dout), W'(exp_to));
    chk("final_spur_cnt", W'(spurious_count_dout), W'(exp_spur));
    chk("final_wordC", out_wordC_dout, exp_c);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/test_engine_driver.md
Name: test_engine_driver

Overview:
NIC-side initiator for the test engine handshake. It accepts a packet (wordA/wordB) from the NIC input buffer over a valid/ready handshake and launches it into the test engine with a one-cycle start strobe. It then waits for the engine's done strobe, captures wordC/wordD, and presents the result to the NIC output buffer over a valid/ready handshake. A bounded wait with a timeout keeps a hung engine from stalling the NIC.

Parameters:
WORD_WIDTH, 64 (2 * `CHANNEL_WIDTH), width of each data word.
TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort; legal range 2..65535.
COUNT_WIDTH, 16, width of the packet, timeout and spurious counters.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid_din  in  1  upstream packet available.
in_wordA_din  in  WORD_WIDTH  upstream word A.
in_wordB_din  in  WORD_WIDTH  upstream word B.
in_ready_dout  out  1  driver can accept a packet.
start_strobe_dout  out  1  one-cycle launch pulse to the engine.
wordA_dout  out  WORD_WIDTH  word A to the engine.
wordB_dout  out  WORD_WIDTH  word B to the engine.
done_strobe_din  in  1  engine result-valid pulse.
active_test_engine_din  in  1  engine busy flag; status only.
wordC_din  in  WORD_WIDTH  engine result word C.
wordD_din  in  WORD_WIDTH  engine result word D.
out_valid_dout  out  1  result available downstream.
out_wordC_dout  out  WORD_WIDTH  captured word C.
out_wordD_dout  out  WORD_WIDTH  captured word D.
out_ready_din  in  1  downstream accepts the result.
timeout_dout  out  1  one-cycle pulse on timeout abort.
busy_dout  out  1  high in any state other than IDLE.
packet_count_dout  out  COUNT_WIDTH  completed packets, saturating.
timeout_count_dout  out  COUNT_WIDTH  timeout aborts, saturating.
spurious_count_dout  out  COUNT_WIDTH  done strobes seen outside WAIT, saturating.

Behaviour:
- Reset: every output and internal register goes to 0 (including all data words and counters); FSM goes to IDLE. Reset mid-operation discards the in-flight packet with no timeout pulse.
- FSM states: IDLE, START, WAIT, OUTPUT.
- IDLE: in_ready_dout=1. When in_valid_din & in_ready_dout, latch in_wordA_din/in_wordB_din into wordA_dout/wordB_dout and go to START.
- START (exactly 1 cycle): start_strobe_dout=1; clear the wait counter to 0; go to WAIT.
- Handshake latency: accept at edge N -> start_strobe_dout high during cycle N+1 only.
- wordA_dout/wordB_dout are registered at accept and held stable through START and WAIT; they change only at the next accept.
- Strobe spacing: start_strobe_dout is always low for at least 1 cycle between launches, so the engine always sees a clean rising edge.
- WAIT: counter increments each cycle.
  - done_strobe_din=1: capture wordC_din/wordD_din into out_wordC_dout/out_wordD_dout, increment packet_count_dout, go to OUTPUT.
  - Counter == TIMEOUT_CYCLES-1 with no done: pulse timeout_dout for 1 cycle, increment timeout_count_dout, drop the packet, go to IDLE.
  - Done on the same cycle as the timeout threshold: done wins and no timeout is flagged.
- OUTPUT: out_valid_dout=1 with data held stable until out_valid_dout & out_ready_din, then go to IDLE. out_valid rises the cycle after done is sampled.
- in_ready_dout is 0 in START, WAIT and OUTPUT. A new packet cannot be accepted in the same cycle the result is consumed; minimum packet spacing is 1 IDLE cycle.
- done_strobe_din high outside WAIT: ignored (no data capture), increments spurious_count_dout once per cycle high. A late done arriving after a timeout is counted spurious.
- Counters saturate at all-ones; there is no wrap-around.
- active_test_engine_din does not affect the FSM.

Test Plan:
- Single packet: A=0x1111_1111_1111_1111, B=0x2222_2222_2222_2222; engine model swaps and answers 16 cycles after the strobe; out_ready=1 -> one start pulse, out_valid 1 cycle after done, C=0x2222..., D=0x1111..., packet_count=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> data and out_valid held stable, in_ready=0 throughout; release -> IDLE, in_ready=1 on the next cycle.
- Back-to-back: 4 packets with in_valid held high -> 4 distinct start pulses, each separated by at least one low cycle, results in order, packet_count=4.
- Timeout: engine never answers, TIMEOUT_CYCLES=64 -> timeout_dout pulses exactly once, 64 cycles after START; then in_ready=1 and timeout_count=1. A done arriving later -> spurious_count=1 and no out_valid.
- Edge cases: done on exactly the timeout cycle -> result delivered, no timeout. Done pulsed while IDLE -> spurious_count increments, no capture.
- Reset mid-WAIT: assert reset 5 cycles after start -> all outputs 0 immediately; after release, a new packet completes normally.
